// File: rtl/mcpu_mem_narrow_cli_if.sv
// mcpu_mem_narrow_cli_if
//   Bundles the narrow (32-bit CPU side) request/response signals and the
//   256-bit arbiter client signals of the narrow client adapter.
//   slave  : adapter side (receives narrow requests, drives the client slot)
//   master : environment side (CPU requester plus arbiter client slot)
interface mcpu_mem_narrow_cli_if;
   // narrow side
   logic         nar_valid;
   logic         nar_we;
   logic [29:0]  nar_addr;   // word address [31:2]
   logic [31:0]  nar_wdata;
   logic [3:0]   nar_be;
   logic         nar_flush;
   logic         nar_ready;
   logic         nar_rvalid;
   logic [31:0]  nar_rdata;
   // arbiter client side
   logic         cli_valid;
   logic [2:0]   cli_opcode;
   logic [26:0]  cli_addr;   // line address [31:5]
   logic [255:0] cli_wdata;
   logic [31:0]  cli_wbe;
   logic         cli_stall;
   logic         cli_rvalid;
   logic [255:0] cli_rdata;

   modport slave (
      input  nar_valid, nar_we, nar_addr, nar_wdata, nar_be, nar_flush,
      input  cli_stall, cli_rvalid, cli_rdata,
      output nar_ready, nar_rvalid, nar_rdata,
      output cli_valid, cli_opcode, cli_addr, cli_wdata, cli_wbe
   );

   modport master (
      output nar_valid, nar_we, nar_addr, nar_wdata, nar_be, nar_flush,
      output cli_stall, cli_rvalid, cli_rdata,
      input  nar_ready, nar_rvalid, nar_rdata,
      input  cli_valid, cli_opcode, cli_addr, cli_wdata, cli_wbe
   );
endinterface

// File: rtl/mcpu_mem_narrow_cli.sv
// mcpu_mem_narrow_cli
//   Narrow client adapter for the memory arbiter. Converts 32-bit loads and
//   stores into 256-bit line transactions on one arbiter client slot. A single
//   32-byte line buffer serves repeated loads to the same line without an
//   arbiter round trip; stores are write-through and keep the buffer coherent.
//   One transaction is outstanding at a time.
// Ports
//   clkrst_mem_clk : memory clock, rising edge
//   clkrst_mem_rst : asynchronous active-high reset
//   bus            : narrow request/response + arbiter client (slave modport)
module mcpu_mem_narrow_cli #(
   parameter logic [2:0] OPC_READ  = 3'b000,
   parameter logic [2:0] OPC_WRITE = 3'b001
) (
   input  logic                 clkrst_mem_clk,
   input  logic                 clkrst_mem_rst,
   mcpu_mem_narrow_cli_if.slave bus
);

   typedef enum logic [2:0] {IDLE, WREQ, RREQ, RWAIT, RDONE} state_t;

   state_t        state, state_nxt;

   logic          buf_valid;
   logic [26:0]   buf_tag;
   logic [255:0]  buf_data;
   logic [26:0]   lat_tag;
   logic [2:0]    lat_lane;
   logic          drop;        // fill in flight was flushed: return data, keep buffer invalid

   logic          nar_rvalid;
   logic [31:0]   nar_rdata;
   logic          cli_valid;
   logic [2:0]    cli_opcode;
   logic [26:0]   cli_addr;
   logic [255:0]  cli_wdata;
   logic [31:0]   cli_wbe;

   logic [2:0]    lane;
   logic [26:0]   tag;
   logic          hit;
   logic [31:0]   cur_word;
   logic [31:0]   st_word;

   logic          take_ld_hit, take_ld_miss, take_st, cli_acc, fill;

   assign lane = bus.nar_addr[2:0];
   assign tag  = bus.nar_addr[29:3];
   assign hit  = buf_valid && (buf_tag == tag);

   // buffered word at the request lane, with the store bytes merged in
   always_comb begin
      cur_word = buf_data[{lane, 5'b0} +: 32];
      st_word  = cur_word;
      for (int b = 0; b < 4; b++)
         if (bus.nar_be[b]) st_word[b*8 +: 8] = bus.nar_wdata[b*8 +: 8];
   end

   always_ff @(posedge clkrst_mem_clk or posedge clkrst_mem_rst) begin
      if (clkrst_mem_rst) state <= IDLE;
      else                state <= state_nxt;
   end

   always_comb begin
      state_nxt    = state;
      take_ld_hit  = 1'b0;
      take_ld_miss = 1'b0;
      take_st      = 1'b0;
      cli_acc      = 1'b0;
      fill         = 1'b0;
      case (state)
         IDLE: if (bus.nar_valid) begin
            if (bus.nar_we) begin
               take_st   = 1'b1;
               state_nxt = WREQ;
            end else if (hit) begin
               take_ld_hit = 1'b1;
            end else begin
               take_ld_miss = 1'b1;
               state_nxt    = RREQ;
            end
         end
         WREQ: if (!bus.cli_stall) begin
            cli_acc   = 1'b1;
            state_nxt = IDLE;
         end
         RREQ: if (!bus.cli_stall) begin
            cli_acc = 1'b1;
            // data returning in the acceptance cycle is taken as if in RWAIT
            if (bus.cli_rvalid) begin
               fill      = 1'b1;
               state_nxt = RDONE;
            end else begin
               state_nxt = RWAIT;
            end
         end
         RWAIT: if (bus.cli_rvalid) begin
            fill      = 1'b1;
            state_nxt = RDONE;
         end
         RDONE:   state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clkrst_mem_clk or posedge clkrst_mem_rst) begin
      if (clkrst_mem_rst) begin
         buf_valid  <= 1'b0;
         buf_tag    <= '0;
         buf_data   <= '0;
         lat_tag    <= '0;
         lat_lane   <= '0;
         drop       <= 1'b0;
         nar_rvalid <= 1'b0;
         nar_rdata  <= '0;
         cli_valid  <= 1'b0;
         cli_opcode <= '0;
         cli_addr   <= '0;
         cli_wdata  <= '0;
         cli_wbe    <= '0;
      end else begin
         nar_rvalid <= 1'b0;

         if (take_ld_hit) begin
            nar_rvalid <= 1'b1;
            nar_rdata  <= cur_word;
         end

         if (state == RDONE) begin
            nar_rvalid <= 1'b1;
            nar_rdata  <= buf_data[{lat_lane, 5'b0} +: 32];
         end

         if (take_ld_miss) begin
            lat_tag    <= tag;
            lat_lane   <= lane;
            drop       <= 1'b0;
            cli_valid  <= 1'b1;
            cli_opcode <= OPC_READ;
            cli_addr   <= tag;
            cli_wbe    <= '0;
         end

         if (take_st) begin
            cli_valid  <= 1'b1;
            cli_opcode <= OPC_WRITE;
            cli_addr   <= tag;
            cli_wdata  <= {8{bus.nar_wdata}};
            cli_wbe    <= {28'b0, bus.nar_be} << {lane, 2'b00};
            if (hit) buf_data[{lane, 5'b0} +: 32] <= st_word;
         end

         if (cli_acc) cli_valid <= 1'b0;

         if (bus.nar_flush && (state == RREQ || state == RWAIT)) drop <= 1'b1;

         // flush clears after any same-cycle hit has already read the buffer
         if (bus.nar_flush) buf_valid <= 1'b0;

         if (fill) begin
            buf_data  <= bus.cli_rdata;
            buf_tag   <= lat_tag;
            buf_valid <= !(drop || bus.nar_flush);
         end
      end
   end

   assign bus.nar_ready  = (state == IDLE);
   assign bus.nar_rvalid = nar_rvalid;
   assign bus.nar_rdata  = nar_rdata;
   assign bus.cli_valid  = cli_valid;
   assign bus.cli_opcode = cli_opcode;
   assign bus.cli_addr   = cli_addr;
   assign bus.cli_wdata  = cli_wdata;
   assign bus.cli_wbe    = cli_wbe;

endmodule

// File: tb/tb_mcpu_mem_narrow_cli.sv
// tb_mcpu_mem_narrow_cli
//   Scoreboard bench for the narrow client adapter. Loads push their expected
//   data and arrival cycle; the per-cycle monitor pops them on nar_rvalid.
//   A small arbiter model returns line data one cycle after acceptance.
module tb_mcpu_mem_narrow_cli;
   localparam logic [2:0] OPC_READ  = 3'b000;
   localparam logic [2:0] OPC_WRITE = 3'b001;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   mcpu_mem_narrow_cli_if bus ();

   mcpu_mem_narrow_cli #(.OPC_READ(OPC_READ), .OPC_WRITE(OPC_WRITE)) dut (
      .clkrst_mem_clk (clk),
      .clkrst_mem_rst (rst),
      .bus            (bus)
   );

   typedef struct { logic [31:0] data; int due; } exp_t;

   int           n_checks = 0;
   int           n_errors = 0;
   int           cyc = 0;
   exp_t         sb[$];
   logic [31:0]  mem [logic [29:0]];

   // monitor state
   int           rv_seen = 0;
   int           cli_reqs = 0;
   int           cli_cycles = 0;
   bit           prev_cv = 1'b0;
   logic [2:0]   last_op = '0;
   logic [26:0]  last_addr = '0;
   logic [31:0]  last_wbe = '0;
   logic [255:0] last_wd = '0;

   // arbiter model controls
   int           stall_req = 0;
   int           stall_used = 0;
   int           stray_req = 0;
   int           stray_done = 0;

   // default memory: word k of line L holds 0x1000_0000 + (L-0x80)*0x100 + k
   function automatic logic [31:0] mem_rd(input logic [29:0] wa);
      if (mem.exists(wa)) return mem[wa];
      return 32'h1000_0000 + ((32'(wa[29:3]) - 32'h80) << 8) + 32'(wa[2:0]);
   endfunction

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                         input logic [3:0] be);
      logic [31:0] r;
      r = old;
      for (int b = 0; b < 4; b++) if (be[b]) r[b*8 +: 8] = wd[b*8 +: 8];
      return r;
   endfunction

   assign bus.cli_stall = bus.cli_valid && (stall_used < stall_req);

   always @(posedge clk) begin
      if (!bus.cli_valid)     stall_used <= 0;
      else if (bus.cli_stall) stall_used <= stall_used + 1;
      bus.cli_rvalid <= 1'b0;
      if (bus.cli_valid && !bus.cli_stall && bus.cli_opcode == OPC_READ) begin
         bus.cli_rvalid <= 1'b1;
         for (int k = 0; k < 8; k++)
            bus.cli_rdata[k*32 +: 32] <= mem_rd({bus.cli_addr, 3'(k)});
      end else if (stray_done != stray_req) begin
         bus.cli_rvalid <= 1'b1;
         bus.cli_rdata  <= {8{32'hBAD0_0BAD}};
         stray_done     <= stray_req;
      end
   end

   task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // one clock; samples outputs on the falling edge
   task automatic tick();
      exp_t e;
      @(negedge clk);
      cyc++;
      if (sb.size() > 0 && cyc > sb[0].due && bus.nar_rvalid !== 1'b1) begin
         e = sb.pop_front();
         chk("rv_missing", 256'(cyc), 256'(e.due));
      end
      if (bus.nar_rvalid === 1'b1) begin
         rv_seen++;
         if (sb.size() == 0) begin
            chk("rv_unexpected", 256'(bus.nar_rvalid), 256'(0));
         end else begin
            e = sb.pop_front();
            chk("rv_data", 256'(bus.nar_rdata), 256'(e.data));
            chk("rv_cycle", 256'(cyc), 256'(e.due));
         end
      end
      if (bus.cli_valid === 1'b1) begin
         cli_cycles++;
         if (prev_cv) begin
            chk("cli_hold", 256'({bus.cli_opcode, bus.cli_addr, bus.cli_wbe}),
                256'({last_op, last_addr, last_wbe}));
            chk("cli_hold_wdata", bus.cli_wdata, last_wd);
         end else begin
            cli_reqs++;
         end
         last_op   = bus.cli_opcode;
         last_addr = bus.cli_addr;
         last_wbe  = bus.cli_wbe;
         last_wd   = bus.cli_wdata;
      end
      prev_cv = (bus.cli_valid === 1'b1);
   endtask

   task automatic issue(input bit we, input logic [29:0] a, input logic [31:0] wd,
                        input logic [3:0] be, input bit fl, input int lat,
                        input logic [31:0] exp, input bit push);
      int n;
      n = 0;
      bus.nar_valid = 1'b1;
      bus.nar_we    = we;
      bus.nar_addr  = a;
      bus.nar_wdata = wd;
      bus.nar_be    = be;
      bus.nar_flush = fl;
      while (bus.nar_ready !== 1'b1 && n < 50) begin
         tick();
         n++;
      end
      chk("req_ready", 256'(bus.nar_ready), 256'(1));
      if (we) mem[a] = merge(mem_rd(a), wd, be);
      if (push) sb.push_back('{exp, cyc + lat});
      tick();
      bus.nar_valid = 1'b0;
      bus.nar_flush = 1'b0;
   endtask

   task automatic drain(input int max);
      int n;
      n = 0;
      while (sb.size() > 0 && n < max) begin
         tick();
         n++;
      end
      chk("drain", 256'(sb.size()), 256'(0));
      sb.delete();
   endtask

   task automatic wait_ready(input int max);
      int n;
      n = 0;
      while (bus.nar_ready !== 1'b1 && n < max) begin
         tick();
         n++;
      end
      chk("wait_ready", 256'(bus.nar_ready), 256'(1));
   endtask

   task automatic chk_idle_outputs(input string tag);
      chk({tag, "_ready"}, 256'(bus.nar_ready), 256'(1));
      chk({tag, "_rvalid"}, 256'(bus.nar_rvalid), 256'(0));
      chk({tag, "_rdata"}, 256'(bus.nar_rdata), 256'(0));
      chk({tag, "_cli"}, 256'({bus.cli_valid, bus.cli_opcode, bus.cli_addr, bus.cli_wbe}), 256'(0));
      chk({tag, "_wdata"}, bus.cli_wdata, 256'(0));
   endtask

   initial begin
      int r0, c0, v0;
      bus.nar_valid = 1'b0;
      bus.nar_we    = 1'b0;
      bus.nar_addr  = '0;
      bus.nar_wdata = '0;
      bus.nar_be    = '0;
      bus.nar_flush = 1'b0;

      tick();
      tick();
      chk_idle_outputs("reset");
      rst = 1'b0;
      tick();

      // first load misses: line 0x80, word 0
      r0 = cli_reqs;
      issue(1'b0, 30'h400, '0, '0, 1'b0, 4, 32'h1000_0000, 1'b1);
      drain(20);
      chk("miss_req_cnt", 256'(cli_reqs - r0), 256'(1));
      chk("miss_req", 256'({last_op, last_addr, last_wbe}), 256'({OPC_READ, 27'h80, 32'h0}));

      // words 1..7 hit back-to-back
      r0 = cli_reqs;
      for (int w = 1; w < 8; w++)
         issue(1'b0, 30'h400 + 30'(w), '0, '0, 1'b0, 1, 32'h1000_0000 + 32'(w), 1'b1);
      drain(10);
      chk("hit_no_req", 256'(cli_reqs - r0), 256'(0));

      // store to buffered word 5 with three stall cycles
      stall_req = 3;
      c0 = cli_cycles;
      issue(1'b1, 30'h405, 32'hDEAD_BEEF, 4'b0110, 1'b0, 0, '0, 1'b0);
      wait_ready(20);
      stall_req = 0;
      chk("st_valid_cycles", 256'(cli_cycles - c0), 256'(4));
      chk("st_req", 256'({last_op, last_addr, last_wbe}), 256'({OPC_WRITE, 27'h80, 32'h0060_0000}));
      chk("st_wdata", last_wd, {8{32'hDEAD_BEEF}});
      // bytes 1 and 2 take 0xBE and 0xAD from the store data
      v0 = rv_seen;
      r0 = cli_reqs;
      issue(1'b0, 30'h405, '0, '0, 1'b0, 1, 32'h10AD_BE05, 1'b1);
      drain(10);
      chk("st_hit_no_req", 256'(cli_reqs - r0), 256'(0));

      // store with no byte enables, to a line not buffered
      issue(1'b1, 30'h603, 32'h1234_5678, 4'b0000, 1'b0, 0, '0, 1'b0);
      wait_ready(20);
      chk("st_be0_req", 256'({last_op, last_addr, last_wbe}), 256'({OPC_WRITE, 27'hC0, 32'h0}));
      chk("st_be0_wdata", last_wd, {8{32'h1234_5678}});

      // flush while the fill is in RWAIT: data returned, buffer left invalid
      r0 = cli_reqs;
      issue(1'b0, 30'h408, '0, '0, 1'b0, 4, mem_rd(30'h408), 1'b1);
      tick();
      bus.nar_flush = 1'b1;
      tick();
      bus.nar_flush = 1'b0;
      drain(20);
      issue(1'b0, 30'h409, '0, '0, 1'b0, 4, mem_rd(30'h409), 1'b1);
      drain(20);
      chk("flush_remiss_cnt", 256'(cli_reqs - r0), 256'(2));
      chk("flush_remiss_req", 256'({last_op, last_addr}), 256'({OPC_READ, 27'h81}));

      // flush together with a hit: hit still served, next load misses
      r0 = cli_reqs;
      issue(1'b0, 30'h40A, '0, '0, 1'b1, 1, 32'h1000_0102, 1'b1);
      issue(1'b0, 30'h40B, '0, '0, 1'b0, 4, 32'h1000_0103, 1'b1);
      drain(20);
      chk("flush_hit_cnt", 256'(cli_reqs - r0), 256'(1));

      // stray cli_rvalid while idle: no response, buffer untouched
      v0 = rv_seen;
      r0 = cli_reqs;
      stray_req = stray_req + 1;
      repeat (4) tick();
      chk("stray_no_rv", 256'(rv_seen - v0), 256'(0));
      issue(1'b0, 30'h40C, '0, '0, 1'b0, 1, 32'h1000_0104, 1'b1);
      drain(10);
      chk("stray_no_req", 256'(cli_reqs - r0), 256'(0));

      // reset while waiting for fill data
      v0 = rv_seen;
      issue(1'b0, 30'h500, '0, '0, 1'b0, 0, '0, 1'b0);
      tick();
      rst = 1'b1;
      tick();
      chk_idle_outputs("midrst");
      tick();
      rst = 1'b0;
      repeat (4) tick();
      chk("midrst_no_rv", 256'(rv_seen - v0), 256'(0));
      chk_idle_outputs("postrst");
      r0 = cli_reqs;
      issue(1'b0, 30'h40D, '0, '0, 1'b0, 4, 32'h1000_0105, 1'b1);
      drain(20);
      chk("postrst_miss_cnt", 256'(cli_reqs - r0), 256'(1));
      chk("postrst_miss_req", 256'({last_op, last_addr}), 256'({OPC_READ, 27'h81}));

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1);
   end
endmodule
